branch_pred_table: RTL and testbench
====================================

# branch_pred_table

Indexed table of 2-bit saturating counters with a global history register (gshare), forming the branch-prediction stage built around the saturating counter. It accepts lookup requests and returns a registered taken/not-taken prediction one cycle later. It consumes resolved branch decisions on a separate update port, training the addressed counter and shifting the outcome into history.

## Interface
- IDX_W, 4, table index width; table holds 2^IDX_W counters
- HIST_W, 4, global history width; must satisfy 1 <= HIST_W <= IDX_W
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- pred_valid  input  1  lookup request this cycle
- pred_pc  input  IDX_W  low PC bits of branch to predict
- pred_out_valid  output  1  registered; high one cycle after accepted lookup
- pred_taken  output  1  registered prediction (1 = taken)
- pred_state  output  2  registered counter value read for the prediction
- pred_idx  output  IDX_W  registered table index used; returned by consumer on update
- upd_valid  input  1  resolved-branch update this cycle
- upd_idx  input  IDX_W  index to train (pred_idx captured at prediction)
- upd_outcome  input  1  resolved decision (1 = taken)
- ghr  output  HIST_W  current committed global history

## Operation
- Counter encoding: 00 STRONGLY_NOT_TAKEN, 01 WEAKLY_NOT_TAKEN, 10 WEAKLY_TAKEN, 11 STRONGLY_TAKEN; prediction = counter[1].
- Index = pred_pc XOR {zero-extend(ghr) to IDX_W}.
- Lookup: on pred_valid, register pred_idx, pred_state = table[index], pred_taken = table[index][1], pred_out_valid = 1. Without pred_valid, pred_out_valid = 0 next cycle; other pred_* outputs hold.
- Update: on upd_valid, table[upd_idx] increments on outcome 1 and decrements on outcome 0, saturating at 11 and 00 (no wrap). ghr <= {ghr[HIST_W-2:0], upd_outcome} (for HIST_W = 1, ghr <= upd_outcome).
- History is non-speculative: it changes only on updates, never on lookups.
- Only upd_idx is trained; no aliasing protection or tags.

## Timing
- Reset (asynchronous, low): all counters = 01, ghr = 0, pred_out_valid = 0, pred_taken = 0, pred_state = 00, pred_idx = 0, effective immediately without a clock edge.
- Lookup latency: 1 cycle (request at edge N, outputs valid after edge N+1).
- Update latency: the counter and ghr reflect an update after the edge at which upd_valid is sampled.
- Simultaneous lookup and update in the same cycle: the lookup uses the pre-update ghr to form the index and reads the pre-update counter, even when indices match. There is no bypass.
- Back-to-back lookups and updates are accepted every cycle; no stalls or backpressure.
- Reset asserted mid-operation aborts any in-flight prediction (pred_out_valid drops immediately). Updates sampled while reset is low are ignored.

## Test plan
All scenarios use IDX_W=4 and HIST_W=4.
- Reset then lookup pc=3 -> next cycle pred_out_valid=1, pred_idx=3, pred_state=01, pred_taken=0; ghr=0000.
- Three taken updates to idx 5 -> ghr=0111; lookup pc=2 (idx 5) -> pred_state=11, pred_taken=1. A fourth taken update to idx 5 -> ghr=1111 and counter stays 11 (check via lookup pc=10 -> pred_state=11).
- After reset, two not-taken updates to idx 9 -> ghr=0000; lookup pc=9 -> pred_state=00. A third not-taken update -> counter stays 00.
- Hysteresis: after reset, taken update to idx 6 -> ghr=0001; lookup pc=7 -> idx 6, state 10, taken 1. Not-taken update to idx 6 -> ghr=0010; lookup pc=4 -> idx 6, state 01, taken 0.
- Simultaneous lookup and update: after reset, same cycle pred_valid with pc=0 and upd_valid with idx 0, outcome 1 -> pred_idx=0, pred_state=01. Next lookup pc=1 (ghr=0001, idx 0) -> pred_state=10.
- Assert reset between clock edges while pred_out_valid=1 and ghr is non-zero -> pred_out_valid, pred_taken, pred_state, pred_idx, and ghr read 0 immediately. After release, lookup of any idx -> pred_state=01.

Source files
------------

// File: rtl/branch_pred_table.sv
// gshare predictor: 2^IDX_W 2-bit saturating counters indexed by pc ^ committed history.
// Lookup result is registered one cycle later; updates train one counter and shift history; never stalls.
module branch_pred_table #(
  parameter int IDX_W  = 4,
  parameter int HIST_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pred_valid,
  input  logic [IDX_W-1:0]  i_pred_pc,
  output logic              o_pred_out_valid,
  output logic              o_pred_taken,
  output logic [1:0]        o_pred_state,
  output logic [IDX_W-1:0]  o_pred_idx,
  input  logic              i_upd_valid,
  input  logic [IDX_W-1:0]  i_upd_idx,
  input  logic              i_upd_outcome,
  output logic [HIST_W-1:0] o_ghr
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]        r_table [DEPTH];
  logic [HIST_W-1:0] r_ghr;
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_rd;
  logic [1:0]        w_cur;
  logic [1:0]        w_nxt;
  logic [HIST_W-1:0] w_ghr_nxt;

  // Reads see pre-update table and history, so a same-cycle update is never bypassed.
  assign w_idx = i_pred_pc ^ IDX_W'(r_ghr);
  assign w_rd  = r_table[w_idx];
  assign w_cur = r_table[i_upd_idx];

  always_comb begin
    w_nxt = w_cur;
    if (i_upd_outcome && (w_cur != 2'b11)) begin
      w_nxt = w_cur + 2'd1;
    end else if (!i_upd_outcome && (w_cur != 2'b00)) begin
      w_nxt = w_cur - 2'd1;
    end
  end

  generate
    if (HIST_W == 1) begin : g_hist1
      assign w_ghr_nxt = i_upd_outcome;
    end else begin : g_histn
      assign w_ghr_nxt = {r_ghr[HIST_W-2:0], i_upd_outcome};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= 2'b01;
      end
      r_ghr <= '0;
    end else if (i_upd_valid) begin
      r_table[i_upd_idx] <= w_nxt;
      r_ghr              <= w_ghr_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pred_out_valid <= 1'b0;
      o_pred_taken     <= 1'b0;
      o_pred_state     <= 2'b00;
      o_pred_idx       <= '0;
    end else begin
      o_pred_out_valid <= i_pred_valid;
      if (i_pred_valid) begin
        o_pred_taken <= w_rd[1];
        o_pred_state <= w_rd;
        o_pred_idx   <= w_idx;
      end
    end
  end

  assign o_ghr = r_ghr;

endmodule

// File: tb/tb_branch_pred_table.sv
// Directed test-plan steps followed by random traffic, checked against an integer gshare model.
module tb_branch_pred_table;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pred_valid = 1'b0;
  logic [3:0] pred_pc = '0;
  logic       pred_out_valid;
  logic       pred_taken;
  logic [1:0] pred_state;
  logic [3:0] pred_idx;
  logic       upd_valid = 1'b0;
  logic [3:0] upd_idx = '0;
  logic       upd_outcome = 1'b0;
  logic [3:0] ghr;

  int errors = 0;
  int checks = 0;

  // Reference model: counters as plain integers 0..3, history as an integer mod 16.
  int m_tbl [16];
  int m_ghr;
  int e_pv, e_pt, e_ps, e_pidx;

  always #5 clk = ~clk;

  branch_pred_table #(.IDX_W(4), .HIST_W(4)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_pred_valid     (pred_valid),
    .i_pred_pc        (pred_pc),
    .o_pred_out_valid (pred_out_valid),
    .o_pred_taken     (pred_taken),
    .o_pred_state     (pred_state),
    .o_pred_idx       (pred_idx),
    .i_upd_valid      (upd_valid),
    .i_upd_idx        (upd_idx),
    .i_upd_outcome    (upd_outcome),
    .o_ghr            (ghr)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pred_out_valid"}, int'(pred_out_valid), e_pv);
    chk({tag, ".pred_taken"},     int'(pred_taken),     e_pt);
    chk({tag, ".pred_state"},     int'(pred_state),     e_ps);
    chk({tag, ".pred_idx"},       int'(pred_idx),       e_pidx);
    chk({tag, ".ghr"},            int'(ghr),            m_ghr);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_tbl[i] = 1;
    m_ghr = 0;
    e_pv = 0; e_pt = 0; e_ps = 0; e_pidx = 0;
  endtask

  // One clock: drive at negedge, predict from pre-update model, then apply update.
  task automatic step(input string tag, input bit pv, input int pc,
                      input bit uv, input int ui, input bit uo);
    int idx;
    @(negedge clk);
    pred_valid  = pv;
    pred_pc     = 4'(pc);
    upd_valid   = uv;
    upd_idx     = 4'(ui);
    upd_outcome = uo;
    e_pv = pv ? 1 : 0;
    if (pv) begin
      idx    = (pc ^ m_ghr) % 16;
      e_pidx = idx;
      e_ps   = m_tbl[idx];
      e_pt   = (m_tbl[idx] >= 2) ? 1 : 0;
    end
    if (uv) begin
      if (uo) m_tbl[ui] = (m_tbl[ui] < 3) ? m_tbl[ui] + 1 : 3;
      else    m_tbl[ui] = (m_tbl[ui] > 0) ? m_tbl[ui] - 1 : 0;
      m_ghr = (m_ghr * 2 + (uo ? 1 : 0)) % 16;
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  // Reset held across one edge with an update presented; the update must be ignored.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pred_valid = 1'b1; pred_pc = 4'd7;
    upd_valid = 1'b1; upd_idx = 4'd2; upd_outcome = 1'b1;
    model_reset();
    #1;
    chk_all("reset_async");
    @(posedge clk);
    #1;
    chk_all("reset_held");
    @(negedge clk);
    pred_valid = 1'b0; upd_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    chk_all("reset_initial");
    do_reset();

    step("lookup_pc3", 1, 3, 0, 0, 0);

    do_reset();
    step("t5_a", 0, 0, 1, 5, 1);
    step("t5_b", 0, 0, 1, 5, 1);
    step("t5_c", 0, 0, 1, 5, 1);
    chk("ghr_0111", int'(ghr), 7);
    step("lookup_pc2", 1, 2, 0, 0, 0);
    chk("sat_hi_state", int'(pred_state), 3);
    step("t5_d", 0, 0, 1, 5, 1);
    step("lookup_pc10", 1, 10, 0, 0, 0);
    step("hold_idle", 0, 0, 0, 0, 0);

    do_reset();
    step("nt9_a", 0, 0, 1, 9, 0);
    step("nt9_b", 0, 0, 1, 9, 0);
    step("lookup_pc9", 1, 9, 0, 0, 0);
    step("nt9_c", 0, 0, 1, 9, 0);
    step("lookup_pc9_sat", 1, 9, 0, 0, 0);
    chk("sat_lo_state", int'(pred_state), 0);

    do_reset();
    step("hyst_t6", 0, 0, 1, 6, 1);
    step("lookup_pc7", 1, 7, 0, 0, 0);
    step("hyst_nt6", 0, 0, 1, 6, 0);
    step("lookup_pc4", 1, 4, 0, 0, 0);
    chk("hyst_taken", int'(pred_taken), 0);

    do_reset();
    step("simul", 1, 0, 1, 0, 1);
    chk("simul_no_bypass", int'(pred_state), 1);
    step("lookup_pc1", 1, 1, 0, 0, 0);

    // Mid-cycle reset while a prediction is valid and history is non-zero.
    step("mid_upd", 0, 0, 1, 5, 1);
    step("mid_lookup", 1, 2, 0, 0, 0);
    #2;
    pred_valid = 1'b0; upd_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_lookup", 1, 13, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      step("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
